pl_mem_arbiter: RTL and testbench
=================================

Name: pl_mem_arbiter

Overview:
- Shares one single-ported unified memory between two requesters: the IF stage (instruction fetch, read-only) and the MEM stage (data load/store).
- Serialises requests, applies data-first priority with an anti-starvation limit for fetch, and drops a fetch response when the fetch request is withdrawn (branch flush).
- Times out hung memory transactions.
- Sits between the pipelined CPU stages and the external memory model; the stall logic consumes the ack signals.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- STREAK_MAX, 4, consecutive data grants allowed while a fetch is pending before the fetch is forced next.
- TIMEOUT, 64, cycles waiting for mem_ready before the transaction is aborted with an error.

Ports:
- clk  in  1  clock, rising edge.
- clrn  in  1  asynchronous active-low reset.
- i_req  in  1  fetch request; held with i_addr until i_ack, or withdrawn (flush).
- i_addr  in  AW  fetch address.
- i_ack  out  1  one-cycle pulse; i_rdata valid this cycle.
- i_rdata  out  DW  fetched instruction.
- d_req  in  1  data request; held stable with d_we/d_addr/d_wdata until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_ack  out  1  one-cycle pulse; d_rdata valid this cycle for loads.
- d_rdata  out  DW  load data.
- err  out  1  one-cycle pulse coincident with the ack of a timed-out transaction.
- mem_en  out  1  memory transaction active; held until completion.
- mem_we  out  1  write enable, valid while mem_en.
- mem_addr  out  AW  address, held while mem_en.
- mem_wdata  out  DW  write data, held while mem_en.
- mem_rdata  in  DW  read data, valid when mem_ready.
- mem_ready  in  1  transaction complete this cycle.

Behaviour:
- Reset (clrn low, asynchronous): state IDLE; streak counter and timeout counter 0.
- Reset values of outputs: mem_en, mem_we, i_ack, d_ack, err all 0; mem_addr, mem_wdata, i_rdata, d_rdata all 0.
- Reset mid-transaction abandons the transaction; no ack is issued.
- States: IDLE, BUSY_I, BUSY_D.
- IDLE, requester masking: a requester whose ack is high this cycle is masked, so a held-over req is not re-granted.
- IDLE, grant decision:
  - d_req and i_req both pending with streak == STREAK_MAX: grant fetch, go to BUSY_I.
  - Otherwise d_req: grant data, go to BUSY_D.
  - Otherwise i_req: grant fetch, go to BUSY_I.
- On grant edge (all registered): mem_en=1; mem_we=d_we for data, 0 for fetch; mem_addr and mem_wdata latched from the granted requester.
- Streak counter:
  - Data grant while i_req pending: streak increments, saturating at STREAK_MAX.
  - Any fetch grant: streak clears.
  - Data grant with no i_req pending: streak clears.
- BUSY_x, completion: mem_ready=1 at an edge causes:
  - mem_en=0, mem_we=0;
  - the matching ack pulses the next cycle with rdata = mem_rdata captured at that edge;
  - return to IDLE.
- BUSY_x, timeout: timeout counter increments each BUSY cycle without mem_ready. When it reaches TIMEOUT-1:
  - treat as completion;
  - rdata = 0 and err=1 together with the ack;
  - counter clears.
- Fetch flush: if i_req is 0 in any BUSY_I cycle, set a drop flag. The memory transaction still completes (mem_en is held until mem_ready or timeout), but i_ack and err are suppressed; the drop flag clears on return to IDLE.
- Data requests are never flushed; d_req falling in BUSY_D is a protocol violation and is not checked.
- Latency: request first seen in IDLE at cycle 0 → mem_en in cycle 1 → with mem_ready in cycle 1, ack in cycle 2. Minimum 2 cycles per transaction, 1 transaction per 2 cycles.
- Simultaneous events:
  - mem_ready and timeout in the same cycle: mem_ready wins, err=0.
  - A new req arriving during BUSY is only evaluated in IDLE.
- Outputs other than acks and err hold their last value when not being updated.

Decomposition:
- Shared package pl_mem_arb_pkg: state encoding (IDLE=2'b00, BUSY_I=2'b01, BUSY_D=2'b10) and grant-select constants.
- One sub-module, pl_arb_timeout_counter: counter with clear/enable inputs and terminal-count output, parameterised by TIMEOUT.
- Streak logic stays inline.

Test Plan:
- Reset mid-BUSY_D: assert clrn=0 during a store → mem_en=0 immediately, no d_ack after release, state IDLE, then a fresh i_req is served normally.
- Single fetch, zero-wait: i_req, i_addr=0x40, mem_ready in cycle 1, mem_rdata=0x20010005 → mem_en in cycle 1 with mem_addr=0x40, mem_we=0; i_ack in cycle 2 with i_rdata=0x20010005.
- Contention: i_req and d_req (load, d_addr=0x100) both asserted in cycle 0 → data is granted first (mem_addr=0x100); fetch is granted in IDLE after d_ack.
- Starvation: i_req held constantly, d_req re-asserted immediately after each d_ack → exactly 4 data grants, then 1 fetch grant, streak reset, pattern repeats.
- Flush: fetch granted with 3-cycle memory latency, i_req dropped in cycle 2 → mem_en held until mem_ready, no i_ack; a pending d_req is then granted.
- Timeout: store granted, mem_ready never asserted → mem_en high for 64 cycles, then d_ack=1 and err=1 in the same cycle, d_rdata=0, state IDLE.

Source files
------------

// File: rtl/pl_mem_arb_pkg.sv
// Shared encodings for the IF/MEM unified-memory arbiter.
package pl_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY_I = 2'b01,
    BUSY_D = 2'b10
  } arb_state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_I    = 2'b01,
    GNT_D    = 2'b10
  } gnt_t;

endpackage

// File: rtl/pl_arb_timeout_counter.sv
// Busy-cycle counter; tc flags the last cycle before a hung transaction is aborted.
module pl_arb_timeout_counter #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic clrn,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt;

  assign tc = (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pl_mem_arbiter.sv
// Arbitrates the IF and MEM stages onto one single-ported memory with
// data-first priority, fetch anti-starvation, fetch flush and transaction timeout.
//
// state  | meaning
// IDLE   | no transaction; pick a requester (ack-cycle requesters are masked)
// BUSY_I | fetch transaction on the memory port
// BUSY_D | load/store transaction on the memory port
module pl_mem_arbiter
  import pl_mem_arb_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STREAK_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready
);

  localparam int SW = $clog2(STREAK_MAX + 1);

  arb_state_t    state;
  gnt_t          gnt;
  logic [SW-1:0] streak;
  logic          drop;
  logic          busy;
  logic          tc;
  logic          done;
  logic          tmo;
  logic          i_pend;
  logic          d_pend;

  assign busy   = (state != IDLE);
  assign done   = busy && (mem_ready || tc);
  // mem_ready takes precedence over a coincident timeout
  assign tmo    = busy && !mem_ready && tc;
  assign i_pend = i_req && !i_ack;
  assign d_pend = d_req && !d_ack;

  always_comb begin
    gnt = GNT_NONE;
    if (d_pend && i_pend && (streak == SW'(STREAK_MAX))) gnt = GNT_I;
    else if (d_pend)                                     gnt = GNT_D;
    else if (i_pend)                                     gnt = GNT_I;
  end

  pl_arb_timeout_counter #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk  (clk),
    .clrn (clrn),
    .clr  (!busy || mem_ready),
    .en   (busy && !mem_ready),
    .tc   (tc)
  );

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state     <= IDLE;
      streak    <= '0;
      drop      <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      err       <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          drop <= 1'b0;
          if (gnt == GNT_I) begin
            state    <= BUSY_I;
            mem_en   <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= i_addr;
            streak   <= '0;
          end else if (gnt == GNT_D) begin
            state     <= BUSY_D;
            mem_en    <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            if (!i_req)                            streak <= '0;
            else if (streak != SW'(STREAK_MAX))    streak <= streak + 1'b1;
          end
        end
        BUSY_I, BUSY_D: begin
          if ((state == BUSY_I) && !i_req) drop <= 1'b1;
          if (done) begin
            state  <= IDLE;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            if (state == BUSY_D) begin
              d_ack   <= 1'b1;
              d_rdata <= tmo ? '0 : mem_rdata;
              err     <= tmo;
            end else if (!drop && i_req) begin
              i_ack   <= 1'b1;
              i_rdata <= tmo ? '0 : mem_rdata;
              err     <= tmo;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pl_mem_arbiter.sv
// Scoreboard bench for pl_mem_arbiter with a latency-programmable memory model.
module tb_pl_mem_arbiter;

  logic        clk = 1'b0;
  logic        clrn = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        err;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic        is_d;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
  } gnt_rec_t;

  exp_t        sb[$];
  gnt_rec_t    glog[$];
  logic [31:0] mem_arr [logic [31:0]];
  int          lat = 0;
  bit          hang = 1'b0;
  int          busy_cnt = 0;
  bit          en_q = 1'b0;

  pl_mem_arbiter dut (
    .clk       (clk),
    .clrn      (clrn),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_ack     (i_ack),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .err       (err),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return {~a[15:0], a[15:0]};
  endfunction

  function automatic exp_t mk(input logic is_d, input logic [31:0] rdata, input logic e);
    exp_t x;
    x.is_d  = is_d;
    x.rdata = rdata;
    x.err   = e;
    return x;
  endfunction

  // Memory model: mem_ready in the lat-th busy cycle; stores return zero data.
  initial begin
    forever begin
      @(negedge clk);
      if (mem_en && !hang) begin
        if (busy_cnt == lat) begin
          mem_ready = 1'b1;
          mem_rdata = mem_we ? 32'h0 : rd(mem_addr);
          if (mem_we) mem_arr[mem_addr] = mem_wdata;
        end else begin
          mem_ready = 1'b0;
        end
        busy_cnt++;
      end else begin
        mem_ready = 1'b0;
        busy_cnt  = 0;
      end
    end
  end

  // Ack monitor pops the scoreboard; grant monitor logs each new transaction.
  initial begin
    exp_t     e;
    gnt_rec_t g;
    forever begin
      @(negedge clk);
      if (i_ack || d_ack) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_ack: i_ack=%0b d_ack=%0b with empty scoreboard", i_ack, d_ack);
        end else begin
          e = sb.pop_front();
          if (d_ack !== e.is_d || i_ack !== !e.is_d ||
              (e.is_d ? d_rdata : i_rdata) !== e.rdata || err !== e.err) begin
            miscompares++;
            $display("FAIL ack_data: got i_ack=%0b d_ack=%0b rdata=%h err=%0b, want %s_ack rdata=%h err=%0b",
                     i_ack, d_ack, e.is_d ? d_rdata : i_rdata, err, e.is_d ? "d" : "i", e.rdata, e.err);
          end
        end
      end
      if (mem_en && !en_q) begin
        g.we   = mem_we;
        g.addr = mem_addr;
        glog.push_back(g);
      end
      en_q = mem_en;
    end
  end

  task automatic wait_ack(input bit is_d, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(is_d ? d_ack : i_ack) && n < budget);
    vectors++;
    if (!(is_d ? d_ack : i_ack)) begin
      miscompares++;
      $display("FAIL %s_ack_wait: ack=0 after %0d cycles, want 1", is_d ? "d" : "i", budget);
    end
  endtask

  task automatic test_reset;
    #1 clrn = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({mem_en, mem_we, i_ack, d_ack, err} !== 5'b0 || mem_addr !== 32'h0 ||
        mem_wdata !== 32'h0 || i_rdata !== 32'h0 || d_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: en/we/iack/dack/err=%b addr=%h wdata=%h irdata=%h drdata=%h, want all 0",
               {mem_en, mem_we, i_ack, d_ack, err}, mem_addr, mem_wdata, i_rdata, d_rdata);
    end
    clrn = 1'b1;
    @(negedge clk);
    vectors++;
    if (mem_en !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset: mem_en=%b, want 0", mem_en);
    end
  endtask

  task automatic test_single_fetch;
    lat = 0;
    mem_arr[32'h40] = 32'h2001_0005;
    @(negedge clk);
    i_addr = 32'h40;
    i_req  = 1'b1;
    sb.push_back(mk(1'b0, 32'h2001_0005, 1'b0));
    @(negedge clk);
    vectors++;
    if (mem_en !== 1'b1 || mem_addr !== 32'h40 || mem_we !== 1'b0 || i_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch_grant: en=%b addr=%h we=%b i_ack=%b, want 1 00000040 0 0", mem_en, mem_addr, mem_we, i_ack);
    end
    @(negedge clk);
    vectors++;
    if (i_ack !== 1'b1 || i_rdata !== 32'h2001_0005 || mem_en !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch_ack: i_ack=%b i_rdata=%h mem_en=%b, want 1 20010005 0", i_ack, i_rdata, mem_en);
    end
    i_req = 1'b0;
    @(negedge clk);
    vectors++;
    if (i_ack !== 1'b0 || mem_en !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch_no_regrant: i_ack=%b mem_en=%b, want 0 0", i_ack, mem_en);
    end
  endtask

  task automatic test_contention;
    lat = 1;
    glog.delete();
    @(negedge clk);
    i_addr = 32'h200; i_req = 1'b1;
    d_addr = 32'h100; d_we = 1'b0; d_req = 1'b1;
    sb.push_back(mk(1'b1, rd(32'h100), 1'b0));
    sb.push_back(mk(1'b0, rd(32'h200), 1'b0));
    wait_ack(1'b1, 20);
    d_req = 1'b0;
    wait_ack(1'b0, 20);
    i_req = 1'b0;
    @(negedge clk);
    vectors++;
    if (glog.size() != 2) begin
      miscompares++;
      $display("FAIL contention_count: grants=%0d, want 2", glog.size());
    end else if (glog[0].addr !== 32'h100 || glog[1].addr !== 32'h200) begin
      miscompares++;
      $display("FAIL contention_order: grants=%h,%h, want 00000100,00000200", glog[0].addr, glog[1].addr);
    end
  endtask

  // Fetch is withheld during d_ack cycles so the ack-cycle mask cannot hand it the port;
  // the streak limit alone decides when fetch wins.
  task automatic test_starvation;
    int fetches = 0;
    bit restore = 1'b0;
    bit done = 1'b0;
    lat = 0;
    glog.delete();
    @(negedge clk);
    i_addr = 32'h400; i_req = 1'b1;
    d_addr = 32'h300; d_we = 1'b0; d_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k % 5 == 4) sb.push_back(mk(1'b0, rd(32'h400), 1'b0));
      else            sb.push_back(mk(1'b1, rd(32'h300), 1'b0));
    end
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (restore) begin
        i_req = 1'b1;
        restore = 1'b0;
      end
      if (d_ack && fetches < 2) begin
        i_req = 1'b0;
        restore = 1'b1;
      end
      if (mem_en && !mem_we && mem_addr == 32'h400) begin
        fetches++;
        if (fetches == 2) d_req = 1'b0;
      end
      if (i_ack && fetches == 2) begin
        i_req = 1'b0;
        done = 1'b1;
      end
    end
    i_req = 1'b0;
    d_req = 1'b0;
    vectors++;
    if (!done || glog.size() != 10) begin
      miscompares++;
      $display("FAIL starve_run: done=%0b grants=%0d, want 1 10", done, glog.size());
    end else begin
      for (int k = 0; k < 10; k++) begin
        vectors++;
        if (glog[k].addr !== ((k % 5 == 4) ? 32'h400 : 32'h300)) begin
          miscompares++;
          $display("FAIL starve_grant_%0d: addr=%h, want %h", k, glog[k].addr,
                   (k % 5 == 4) ? 32'h400 : 32'h300);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_flush;
    lat = 2;
    @(negedge clk);
    i_addr = 32'h500; i_req = 1'b1;
    @(negedge clk);
    vectors++;
    if (mem_en !== 1'b1 || mem_addr !== 32'h500) begin
      miscompares++;
      $display("FAIL flush_grant: en=%b addr=%h, want 1 00000500", mem_en, mem_addr);
    end
    d_addr = 32'h600; d_we = 1'b0; d_req = 1'b1;
    sb.push_back(mk(1'b1, rd(32'h600), 1'b0));
    @(negedge clk);
    i_req = 1'b0;
    vectors++;
    if (mem_en !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_hold_c2: mem_en=%b, want 1", mem_en);
    end
    @(negedge clk);
    vectors++;
    if (mem_en !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_hold_c3: mem_en=%b, want 1", mem_en);
    end
    @(negedge clk);
    vectors++;
    if (i_ack !== 1'b0 || mem_en !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_no_ack: i_ack=%b mem_en=%b, want 0 0", i_ack, mem_en);
    end
    @(negedge clk);
    vectors++;
    if (mem_en !== 1'b1 || mem_addr !== 32'h600 || mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_then_data: en=%b addr=%h we=%b, want 1 00000600 0", mem_en, mem_addr, mem_we);
    end
    wait_ack(1'b1, 20);
    d_req = 1'b0;
    lat = 0;
    @(negedge clk);
    i_addr = 32'h40; i_req = 1'b1;
    sb.push_back(mk(1'b0, 32'h2001_0005, 1'b0));
    wait_ack(1'b0, 10);
    i_req = 1'b0;
  endtask

  task automatic test_timeout;
    int en_cnt = 0;
    bit got = 1'b0;
    hang = 1'b1;
    @(negedge clk);
    d_addr = 32'h700; d_we = 1'b1; d_wdata = 32'hDEAD_BEEF; d_req = 1'b1;
    sb.push_back(mk(1'b1, 32'h0, 1'b1));
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      if (mem_en) en_cnt++;
      if (d_ack) got = 1'b1;
    end
    d_req = 1'b0;
    hang = 1'b0;
    vectors++;
    if (!got || en_cnt != 64 || err !== 1'b1 || d_rdata !== 32'h0 ||
        mem_en !== 1'b0 || mem_wdata !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL timeout: ack=%0b en_cycles=%0d err=%b d_rdata=%h mem_en=%b wdata=%h, want 1 64 1 00000000 0 deadbeef",
               got, en_cnt, err, d_rdata, mem_en, mem_wdata);
    end
  endtask

  task automatic test_ready_at_timeout;
    lat = 63;
    @(negedge clk);
    d_addr = 32'h800; d_we = 1'b0; d_req = 1'b1;
    sb.push_back(mk(1'b1, rd(32'h800), 1'b0));
    wait_ack(1'b1, 100);
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL ready_beats_timeout: err=%b, want 0", err);
    end
    d_req = 1'b0;
    lat = 0;
  endtask

  task automatic test_back_to_back;
    lat = 0;
    @(negedge clk);
    d_addr = 32'h900; d_we = 1'b1; d_wdata = 32'h1234_5678; d_req = 1'b1;
    sb.push_back(mk(1'b1, 32'h0, 1'b0));
    @(negedge clk);
    vectors++;
    if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h900 || mem_wdata !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL store_grant: en=%b we=%b addr=%h wdata=%h, want 1 1 00000900 12345678",
               mem_en, mem_we, mem_addr, mem_wdata);
    end
    wait_ack(1'b1, 10);
    d_we = 1'b0;
    sb.push_back(mk(1'b1, 32'h1234_5678, 1'b0));
    wait_ack(1'b1, 10);
    d_req = 1'b0;
  endtask

  task automatic test_reset_mid;
    hang = 1'b1;
    @(negedge clk);
    d_addr = 32'hA00; d_we = 1'b1; d_wdata = 32'h55AA_55AA; d_req = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (mem_en !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_busy: mem_en=%b, want 1", mem_en);
    end
    #2 clrn = 1'b0;
    #1;
    vectors++;
    if (mem_en !== 1'b0 || mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_async: mem_en=%b mem_we=%b, want 0 0", mem_en, mem_we);
    end
    d_req = 1'b0;
    hang = 1'b0;
    @(negedge clk);
    clrn = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      vectors++;
      if (d_ack !== 1'b0 || mem_en !== 1'b0 || err !== 1'b0) begin
        miscompares++;
        $display("FAIL rst_mid_quiet_%0d: d_ack=%b mem_en=%b err=%b, want 0 0 0", c, d_ack, mem_en, err);
      end
    end
    lat = 0;
    i_addr = 32'h40; i_req = 1'b1;
    sb.push_back(mk(1'b0, 32'h2001_0005, 1'b0));
    wait_ack(1'b0, 10);
    i_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_fetch();
    test_contention();
    test_starvation();
    test_flush();
    test_timeout();
    test_ready_at_timeout();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d acks outstanding, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
